// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared defaults, RGB565 constants and layer_id width helper for the VGA layer mixer
package vga_pkg;

   localparam int          COLOR_W_DEF   = 16;
   localparam logic [15:0] KEY_COLOR_DEF = 16'hF81F;

   localparam logic [15:0] RGB565_BLACK   = 16'h0000;
   localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB565_RED     = 16'hF800;
   localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB565_BLUE    = 16'h001F;
   localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;

   // Wide enough to hold every layer index plus the background code NUM_LAYERS.
   function automatic int lid_w(input int num_layers);
      return $clog2(num_layers + 1);
   endfunction

endpackage

// File: rtl/vga_prio_enc.sv
// rtl/vga_prio_enc.sv - priority encoder, lowest set request wins; idx_o = N when nothing is requested
module vga_prio_enc #(
   parameter int N     = 4,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      idx_o   = IDX_W'(N);
      valid_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = IDX_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - layer priority compositing, frame-synchronous mask, collision detect, output pipeline
// Optional colour-key transparency: define VGA_MIXER_COLORKEY_EN.
module vga_layer_mixer
   import vga_pkg::*;
#(
   parameter int                 NUM_LAYERS = 4,
   parameter int                 COLOR_W    = COLOR_W_DEF,
   parameter int                 LATENCY    = 2,
   parameter int                 COLL_A     = 0,
   parameter int                 COLL_B     = 1,
   parameter logic [COLOR_W-1:0] KEY_COLOR  = COLOR_W'(KEY_COLOR_DEF)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            hsync_in,
   input  logic                            vsync_in,
   input  logic                            de_in,
   input  logic                            new_frame,
   input  logic [NUM_LAYERS-1:0]           layer_pe,
   input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_color,
   input  logic [COLOR_W-1:0]              bg_color,
   input  logic                            mask_wr,
   input  logic [NUM_LAYERS-1:0]           layer_mask_in,
   output logic                            vga_hsync,
   output logic                            vga_vsync,
   output logic                            vga_de,
   output logic [COLOR_W-1:0]              vga_rgb,
   output logic [lid_w(NUM_LAYERS)-1:0]    layer_id,
   output logic [NUM_LAYERS-1:0]           mask_active,
   output logic                            coll_valid,
   output logic                            coll_hit,
   output logic [15:0]                     coll_frames
);

   localparam int LID_W = lid_w(NUM_LAYERS);
   localparam int P_W   = 3 + COLOR_W + LID_W;
   localparam logic [P_W-1:0] P_RST = {{(3 + COLOR_W){1'b0}}, LID_W'(NUM_LAYERS)};

   logic [NUM_LAYERS-1:0] mask_q, pend_q;
   logic [NUM_LAYERS-1:0] eff;
   logic [LID_W-1:0]      win_idx;
   logic                  win_valid;
   logic [COLOR_W-1:0]    comp;
   logic [P_W-1:0]        pipe_d;
   logic [P_W-1:0]        pipe_q [LATENCY];
   logic                  hit_now;
   logic                  acc_q, coll_hit_q, coll_valid_q;
   logic [15:0]           coll_frames_q;

   always_comb begin
      eff = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
`ifdef VGA_MIXER_COLORKEY_EN
         eff[i] = layer_pe[i] & mask_q[i] & (layer_color[i*COLOR_W +: COLOR_W] != KEY_COLOR);
`else
         eff[i] = layer_pe[i] & mask_q[i];
`endif
      end
   end

   vga_prio_enc #(.N(NUM_LAYERS), .IDX_W(LID_W)) u_prio (
      .req_i   (eff),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   always_comb begin
      comp = bg_color;
      if (win_valid) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (win_idx == LID_W'(i)) comp = layer_color[i*COLOR_W +: COLOR_W];
         end
      end
      if (!de_in) comp = '0;
   end

   assign pipe_d = {hsync_in, vsync_in, de_in, comp, win_idx};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < LATENCY; s++) pipe_q[s] <= P_RST;
      end else begin
         pipe_q[0] <= pipe_d;
         for (int s = 1; s < LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
      end
   end

   assign {vga_hsync, vga_vsync, vga_de, vga_rgb, layer_id} = pipe_q[LATENCY-1];

   // A write landing on the frame-start cycle bypasses the pending register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '1;
         mask_q <= '1;
      end else begin
         if (mask_wr)   pend_q <= layer_mask_in;
         if (new_frame) mask_q <= mask_wr ? layer_mask_in : pend_q;
      end
   end

   assign hit_now = eff[COLL_A] & eff[COLL_B] & de_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q         <= 1'b0;
         coll_hit_q    <= 1'b0;
         coll_valid_q  <= 1'b0;
         coll_frames_q <= 16'd0;
      end else begin
         coll_valid_q <= new_frame;
         if (new_frame) begin
            coll_hit_q <= acc_q | hit_now;
            acc_q      <= 1'b0;
         end else if (hit_now) begin
            acc_q <= 1'b1;
         end
         if (coll_valid_q && coll_hit_q && coll_frames_q != 16'hFFFF)
            coll_frames_q <= coll_frames_q + 16'd1;
      end
   end

   assign mask_active = mask_q;
   assign coll_valid  = coll_valid_q;
   assign coll_hit    = coll_hit_q;
   assign coll_frames = coll_frames_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb/tb_vga_layer_mixer.sv - directed self-checking bench for vga_layer_mixer (colour-key steps under VGA_MIXER_COLORKEY_EN)
module tb_vga_layer_mixer;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsync_in, vsync_in, de_in, new_frame, mask_wr;
   logic [3:0]  layer_pe, layer_mask_in;
   logic [63:0] layer_color;
   logic [15:0] bg_color;
   logic        vga_hsync, vga_vsync, vga_de, coll_valid, coll_hit;
   logic [15:0] vga_rgb, coll_frames;
   logic [2:0]  layer_id;
   logic [3:0]  mask_active;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   vga_layer_mixer dut (
      .clk           (clk),
      .rst           (rst),
      .hsync_in      (hsync_in),
      .vsync_in      (vsync_in),
      .de_in         (de_in),
      .new_frame     (new_frame),
      .layer_pe      (layer_pe),
      .layer_color   (layer_color),
      .bg_color      (bg_color),
      .mask_wr       (mask_wr),
      .layer_mask_in (layer_mask_in),
      .vga_hsync     (vga_hsync),
      .vga_vsync     (vga_vsync),
      .vga_de        (vga_de),
      .vga_rgb       (vga_rgb),
      .layer_id      (layer_id),
      .mask_active   (mask_active),
      .coll_valid    (coll_valid),
      .coll_hit      (coll_hit),
      .coll_frames   (coll_frames)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      hsync_in = 0; vsync_in = 0; de_in = 0; new_frame = 0; mask_wr = 0;
      layer_pe = 4'b0000; layer_mask_in = 4'b0000;
      layer_color = {16'h3333, 16'h2222, 16'h1111, 16'hAAAA};
      bg_color = 16'h5A5A;
      #1;
      chk("rst_rgb", 32'(vga_rgb), 32'h0);
      chk("rst_id", 32'(layer_id), 32'd4);
      chk("rst_mask", 32'(mask_active), 32'hF);
      chk("rst_cvalid", 32'(coll_valid), 32'h0);
      chk("rst_frames", 32'(coll_frames), 32'h0);
      #1 rst = 1'b0;
      step(1);

      de_in = 1; layer_pe = 4'b0110;
      step(2);
      chk("prio_rgb", 32'(vga_rgb), 32'h1111);
      chk("prio_id", 32'(layer_id), 32'd1);
      layer_pe = 4'b0000;
      step(2);
      chk("bg_rgb", 32'(vga_rgb), 32'h5A5A);
      chk("bg_id", 32'(layer_id), 32'd4);

      de_in = 0; layer_pe = 4'b1111; hsync_in = 1; vsync_in = 1;
      step(1);
      chk("hs_rise_early", 32'(vga_hsync), 32'h0);
      step(1);
      chk("blank_rgb", 32'(vga_rgb), 32'h0);
      chk("blank_id", 32'(layer_id), 32'd0);
      chk("hs_rise", 32'(vga_hsync), 32'h1);
      chk("vs_rise", 32'(vga_vsync), 32'h1);
      chk("blank_de", 32'(vga_de), 32'h0);
      hsync_in = 0;
      step(1);
      chk("hs_fall_early", 32'(vga_hsync), 32'h1);
      step(1);
      chk("hs_fall", 32'(vga_hsync), 32'h0);

      mask_wr = 1; layer_mask_in = 4'b1110;
      step(1);
      mask_wr = 0;
      chk("mask_midframe", 32'(mask_active), 32'hF);
      de_in = 1; layer_pe = 4'b0001;
      step(2);
      chk("mask_l0_still", 32'(vga_rgb), 32'hAAAA);
      de_in = 0; new_frame = 1;
      step(1);
      new_frame = 0;
      chk("mask_applied", 32'(mask_active), 32'hE);
      chk("nf1_valid", 32'(coll_valid), 32'h1);
      chk("nf1_hit", 32'(coll_hit), 32'h0);
      de_in = 1; layer_pe = 4'b0001;
      step(2);
      chk("mask_l0_bg", 32'(vga_rgb), 32'h5A5A);
      chk("mask_l0_id", 32'(layer_id), 32'd4);
      chk("valid_pulse_end", 32'(coll_valid), 32'h0);
      layer_pe = 4'b0011;
      step(2);
      chk("mask_l1_rgb", 32'(vga_rgb), 32'h1111);
      de_in = 0; new_frame = 1; mask_wr = 1; layer_mask_in = 4'b1111;
      step(1);
      new_frame = 0; mask_wr = 0;
      chk("mask_coincident", 32'(mask_active), 32'hF);

      de_in = 1; layer_pe = 4'b0011;
      step(3);
      de_in = 0; layer_pe = 4'b0000;
      step(1);
      chk("coll_no_valid", 32'(coll_valid), 32'h0);
      new_frame = 1;
      step(1);
      new_frame = 0;
      chk("f1_valid", 32'(coll_valid), 32'h1);
      chk("f1_hit", 32'(coll_hit), 32'h1);
      step(1);
      chk("f1_valid_low", 32'(coll_valid), 32'h0);
      chk("f1_hit_held", 32'(coll_hit), 32'h1);
      chk("f1_frames", 32'(coll_frames), 32'd1);
      de_in = 1; layer_pe = 4'b0001;
      step(3);
      de_in = 0; layer_pe = 4'b0000; new_frame = 1;
      step(1);
      new_frame = 0;
      chk("f2_valid", 32'(coll_valid), 32'h1);
      chk("f2_hit", 32'(coll_hit), 32'h0);
      step(1);
      chk("f2_frames", 32'(coll_frames), 32'd1);

      new_frame = 1; mask_wr = 1; layer_mask_in = 4'b1101;
      step(1);
      new_frame = 0; mask_wr = 0;
      chk("mask_l1_off", 32'(mask_active), 32'hD);
      de_in = 1; layer_pe = 4'b0011;
      step(3);
      de_in = 0; layer_pe = 4'b0000; new_frame = 1;
      step(1);
      new_frame = 0;
      chk("masked_valid", 32'(coll_valid), 32'h1);
      chk("masked_hit", 32'(coll_hit), 32'h0);
      new_frame = 1; mask_wr = 1; layer_mask_in = 4'b1111;
      step(1);
      new_frame = 0; mask_wr = 0;
      step(1);
      chk("masked_frames", 32'(coll_frames), 32'd1);

      de_in = 1; layer_pe = 4'b0011;
      step(2);
      chk("pre_rst_rgb", 32'(vga_rgb), 32'hAAAA);
      #3 rst = 1'b1;
      #1;
      chk("arst_rgb", 32'(vga_rgb), 32'h0);
      chk("arst_id", 32'(layer_id), 32'd4);
      chk("arst_mask", 32'(mask_active), 32'hF);
      chk("arst_frames", 32'(coll_frames), 32'd0);
      rst = 1'b0; de_in = 0; layer_pe = 4'b0000;
      step(1);
      new_frame = 1;
      step(1);
      new_frame = 0;
      chk("post_rst_valid", 32'(coll_valid), 32'h1);
      chk("post_rst_hit", 32'(coll_hit), 32'h0);

`ifdef VGA_MIXER_COLORKEY_EN
      layer_color = {16'h3333, 16'h2222, 16'h1111, 16'hF81F};
      de_in = 1; layer_pe = 4'b0011;
      step(2);
      chk("ckey_rgb", 32'(vga_rgb), 32'h1111);
      chk("ckey_id", 32'(layer_id), 32'd1);
      de_in = 0; layer_pe = 4'b0000; new_frame = 1;
      step(1);
      new_frame = 0;
      chk("ckey_hit", 32'(coll_hit), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
